// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with one-word lines.
// Misses and halt-time flushes use a fixed-latency memory handshake.
module data_cache #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned NUM_LINES   = 2048,
    parameter int unsigned MEM_LATENCY = 4
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic [XLEN-1:0] cpu_addr,
    input  logic [7:0]      cpu_wdata [0:3],
    output logic [7:0]      cpu_rdata [0:3],
    input  logic            cpu_re,
    input  logic            cpu_we,
    output logic            stall,
    input  logic            flush,
    output logic            flush_done,
    output logic [XLEN-1:0] mem_addr,
    output logic [7:0]      mem_data_in [0:3],
    input  logic [7:0]      mem_data_out [0:3],
    output logic            mem_write_en
);
    localparam int unsigned IDX  = $clog2(NUM_LINES);
    localparam int unsigned TAGW = XLEN - IDX - 2;
    localparam int unsigned CNTW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [2:0] {StIdle, StWb, StFill, StFlScan, StFlWb, StDone} state_e;

    state_e              state_q, state_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic [IDX-1:0]      ptr_q, ptr_d;
    logic [NUM_LINES-1:0] valid_q, valid_d, dirty_q, dirty_d;
    logic [TAGW-1:0]     tag_q [NUM_LINES];
    logic [XLEN-1:0]     data_q [NUM_LINES];
    logic [XLEN-1:0]     mem_addr_q;

    logic [IDX-1:0]  cpu_idx, wb_idx, line_widx;
    logic [TAGW-1:0] cpu_tag, line_wtag;
    logic [XLEN-1:0] cpu_wword, mem_rword, line_wdata, wb_addr;
    logic            req, hit, cnt_last, ptr_last, line_we, stall_raw;
    logic            unused_addr_lsb;

    assign cpu_idx         = cpu_addr[IDX+1:2];
    assign cpu_tag         = cpu_addr[XLEN-1:IDX+2];
    assign unused_addr_lsb = ^cpu_addr[1:0];
    assign req             = cpu_re | cpu_we;
    assign hit             = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
    assign cnt_last        = (cnt_q == CNTW'(MEM_LATENCY - 1));
    assign ptr_last        = (ptr_q == IDX'(NUM_LINES - 1));
    // Write-back source line: flush pointer during flush, victim at the CPU index otherwise.
    assign wb_idx          = (state_q == StFlWb) ? ptr_q : cpu_idx;
    assign wb_addr         = {tag_q[wb_idx], wb_idx, 2'b00};
    assign flush_done      = (state_q == StDone);
    // Reset forces stall low even while the core still holds a request.
    assign stall           = rst_b & stall_raw;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cpu_wword[8*i +: 8] = cpu_wdata[i];
            mem_rword[8*i +: 8] = mem_data_out[i];
            cpu_rdata[i]        = data_q[cpu_idx][8*i +: 8];
            mem_data_in[i]      = data_q[wb_idx][8*i +: 8];
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ptr_d        = ptr_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        line_we      = 1'b0;
        line_widx    = cpu_idx;
        line_wtag    = cpu_tag;
        line_wdata   = cpu_wword;
        stall_raw    = 1'b1;
        mem_write_en = 1'b0;
        mem_addr     = mem_addr_q;
        unique case (state_q)
            StIdle: begin
                stall_raw = 1'b0;
                if (flush) begin
                    stall_raw = 1'b1;
                    ptr_d     = '0;
                    state_d   = StFlScan;
                end else if (req && hit) begin
                    if (cpu_we) begin
                        line_we          = 1'b1;
                        dirty_d[cpu_idx] = 1'b1;
                    end
                end else if (req) begin
                    stall_raw = 1'b1;
                    cnt_d     = '0;
                    state_d   = (valid_q[cpu_idx] && dirty_q[cpu_idx]) ? StWb : StFill;
                end
            end
            StWb: begin
                mem_write_en = 1'b1;
                mem_addr     = wb_addr;
                cnt_d        = cnt_q + 1'b1;
                if (cnt_last) begin
                    dirty_d[cpu_idx] = 1'b0;
                    cnt_d            = '0;
                    state_d          = StFill;
                end
            end
            StFill: begin
                mem_addr = {cpu_tag, cpu_idx, 2'b00};
                cnt_d    = cnt_q + 1'b1;
                if (cnt_last) begin
                    line_we          = 1'b1;
                    line_wdata       = mem_rword;
                    valid_d[cpu_idx] = 1'b1;
                    dirty_d[cpu_idx] = 1'b0;
                    cnt_d            = '0;
                    state_d          = StIdle;
                end
            end
            StFlScan: begin
                if (valid_q[ptr_q] && dirty_q[ptr_q]) begin
                    cnt_d   = '0;
                    state_d = StFlWb;
                end else if (ptr_last) begin
                    state_d = StDone;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            StFlWb: begin
                mem_write_en = 1'b1;
                mem_addr     = wb_addr;
                cnt_d        = cnt_q + 1'b1;
                if (cnt_last) begin
                    dirty_d[ptr_q] = 1'b0;
                    cnt_d          = '0;
                    if (ptr_last) begin
                        state_d = StDone;
                    end else begin
                        ptr_d   = ptr_q + 1'b1;
                        state_d = StFlScan;
                    end
                end
            end
            StDone: ;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            ptr_q      <= '0;
            valid_q    <= '0;
            dirty_q    <= '0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            valid_q    <= valid_d;
            dirty_q    <= dirty_d;
            mem_addr_q <= mem_addr;
        end
    end

    // Line payload needs no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_q[line_widx]  <= line_wtag;
            data_q[line_widx] <= line_wdata;
        end
    end
endmodule

// File: tb/tb_data_cache.sv
// Directed self-checking bench for data_cache with a small word-addressed memory model.
module tb_data_cache;
    logic        clk = 1'b0;
    logic        rst_b;
    logic [31:0] cpu_addr;
    logic [7:0]  cpu_wdata [0:3];
    logic [7:0]  cpu_rdata [0:3];
    logic        cpu_re, cpu_we, stall, flush, flush_done;
    logic [31:0] mem_addr;
    logic [7:0]  mem_data_in [0:3];
    logic [7:0]  mem_data_out [0:3];
    logic        mem_write_en;

    logic [31:0] wdata_w, rdata_w, mem_in_w;
    logic [31:0] mem [256];
    logic        pl_we;
    logic [31:0] pl_addr, pl_data;

    int n_checks = 0;
    int n_fail   = 0;

    data_cache #(.XLEN(32), .NUM_LINES(16), .MEM_LATENCY(4)) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .cpu_re       (cpu_re),
        .cpu_we       (cpu_we),
        .stall        (stall),
        .flush        (flush),
        .flush_done   (flush_done),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .mem_write_en (mem_write_en)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cpu_wdata[i]        = wdata_w[8*i +: 8];
            rdata_w[8*i +: 8]   = cpu_rdata[i];
            mem_in_w[8*i +: 8]  = mem_data_in[i];
            mem_data_out[i]     = mem[mem_addr[9:2]][8*i +: 8];
        end
    end

    always @(posedge clk) begin
        if (mem_write_en) mem[mem_addr[9:2]] <= mem_in_w;
        else if (pl_we)   mem[pl_addr[9:2]]  <= pl_data;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_b  = 1'b0;
        flush  = 1'b0;
        cpu_re = 1'b0;
        cpu_we = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b1;
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_we = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the access has committed.
    task automatic access(input logic re, input logic we, input logic [31:0] a,
                          input logic [31:0] wd, output int stalls, output int wes,
                          output logic [31:0] wa, output logic [31:0] wdat,
                          output logic [31:0] rd);
        cpu_re = re; cpu_we = we; cpu_addr = a; wdata_w = wd;
        stalls = 0; wes = 0; wa = 0; wdat = 0;
        #1;
        while (stall && stalls < 100) begin
            stalls++;
            if (mem_write_en) begin
                if (wes == 0) begin
                    wa   = mem_addr;
                    wdat = mem_in_w;
                end
                wes++;
            end
            @(posedge clk); #2;
        end
        rd = rdata_w;
        @(posedge clk); #1;
        cpu_re = 1'b0; cpu_we = 1'b0;
    endtask

    initial begin
        int st, we_n, n;
        logic [31:0] wa, wd, rd, first_a, last_a;
        pl_we = 1'b0; pl_addr = 0; pl_data = 0;
        cpu_addr = 0; wdata_w = 0;
        do_reset();
        rst_b = 1'b0;
        #1;
        check_eq("rst_stall", {31'd0, stall}, 32'd0);
        check_eq("rst_mwe", {31'd0, mem_write_en}, 32'd0);
        check_eq("rst_maddr", mem_addr, 32'd0);
        check_eq("rst_fdone", {31'd0, flush_done}, 32'd0);
        @(posedge clk); #1 rst_b = 1'b1;

        // Test 1: clean read miss
        preload(32'h40, 32'hDEADBEEF);
        preload(32'h80, 32'hCAFEF00D);
        access(1'b1, 1'b0, 32'h40, 32'h0, st, we_n, wa, wd, rd);
        check_eq("t1_stall_cycles", st, 5);
        check_eq("t1_mwe_cycles", we_n, 0);
        check_eq("t1_rdata", rd, 32'hDEADBEEF);

        // Test 2: write hit, memory untouched
        access(1'b0, 1'b1, 32'h40, 32'h12345678, st, we_n, wa, wd, rd);
        check_eq("t2_store_stall", st, 0);
        check_eq("t2_mem_unchanged", mem[8'h10], 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'h40, 32'h0, st, we_n, wa, wd, rd);
        check_eq("t2_read_stall", st, 0);
        check_eq("t2_rdata", rd, 32'h12345678);

        // Test 3: dirty eviction of 0x40 by 0x80
        access(1'b1, 1'b0, 32'h80, 32'h0, st, we_n, wa, wd, rd);
        check_eq("t3_stall_cycles", st, 9);
        check_eq("t3_mwe_cycles", we_n, 4);
        check_eq("t3_wb_addr", wa, 32'h40);
        check_eq("t3_wb_data", wd, 32'h12345678);
        check_eq("t3_rdata", rd, 32'hCAFEF00D);
        check_eq("t3_mem_written", mem[8'h10], 32'h12345678);

        // Test 4: flush with dirty lines at indices 1 and 15
        access(1'b0, 1'b1, 32'h04, 32'h000000A1, st, we_n, wa, wd, rd);
        access(1'b0, 1'b1, 32'h3C, 32'h000000B2, st, we_n, wa, wd, rd);
        check_eq("t4_mem1_before", mem[8'h01], 32'h0);
        flush = 1'b1;
        #1;
        check_eq("t4_stall", {31'd0, stall}, 32'd1);
        n = 0; we_n = 0; first_a = 0; last_a = 0;
        while (!flush_done && n < 200) begin
            if (mem_write_en) begin
                we_n++;
                if (we_n == 1) first_a = mem_addr;
                last_a = mem_addr;
            end
            n++;
            @(posedge clk); #2;
        end
        check_eq("t4_fdone", {31'd0, flush_done}, 32'd1);
        check_eq("t4_mwe_cycles", we_n, 8);
        check_eq("t4_first_addr", first_a, 32'h04);
        check_eq("t4_last_addr", last_a, 32'h3C);
        check_eq("t4_mem1", mem[8'h01], 32'h000000A1);
        check_eq("t4_mem15", mem[8'h0F], 32'h000000B2);
        repeat (5) @(posedge clk);
        #2;
        check_eq("t4_fdone_sticky", {31'd0, flush_done}, 32'd1);
        check_eq("t4_stall_held", {31'd0, stall}, 32'd1);

        // Test 5: flush and read miss in the same cycle
        do_reset();
        cpu_re = 1'b1; cpu_addr = 32'h100; flush = 1'b1;
        #1;
        check_eq("t5_stall", {31'd0, stall}, 32'd1);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            if (mem_addr == 32'h100 || mem_write_en) n++;
            @(posedge clk); #2;
        end
        check_eq("t5_no_fill", n, 0);
        check_eq("t5_fdone", {31'd0, flush_done}, 32'd1);
        cpu_re = 1'b0; flush = 1'b0;

        // Test 6: reset during the second write-back cycle
        do_reset();
        access(1'b0, 1'b1, 32'h40, 32'h55AA55AA, st, we_n, wa, wd, rd);
        check_eq("t6_fill_stall", st, 5);
        cpu_re = 1'b1; cpu_addr = 32'h80;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("t6_wb_mwe", {31'd0, mem_write_en}, 32'd1);
        check_eq("t6_wb_addr", mem_addr, 32'h40);
        rst_b = 1'b0;
        #1;
        check_eq("t6_rst_mwe", {31'd0, mem_write_en}, 32'd0);
        check_eq("t6_rst_stall", {31'd0, stall}, 32'd0);
        check_eq("t6_rst_maddr", mem_addr, 32'd0);
        @(posedge clk); #1;
        rst_b = 1'b1; cpu_re = 1'b0;
        access(1'b1, 1'b0, 32'h40, 32'h0, st, we_n, wa, wd, rd);
        check_eq("t6_reread_miss", st, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
